ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu_if.sv | 25 ++
 rtl/ifu.sv | 100 ++++++++++
 tb/tb_ifu.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifu_if.sv
// rtl/ifu_if.sv - fetch unit bundle: imem request/response, decoder handoff, redirect
interface ifu_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  // fetch unit side
  modport master (
    output imem_req, imem_addr, inst, inst_pc, inst_valid,
    input  imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );

  // memory / decoder / branch-resolution side
  modport slave (
    input  imem_req, imem_addr, inst, inst_pc, inst_valid,
    output imem_ack, imem_rdata, inst_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ifu.sv
// rtl/ifu.sv - single-outstanding instruction fetch unit with redirect and stale-response drain
module ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   rst,
  ifu_if.master  bus
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_VALID = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;

  logic        req;
  logic        ack;
  logic [31:0] target;

  // Redirect targets are always word aligned.
  assign target = {bus.redirect_pc[31:2], 2'b00};

  // A request is outstanding in FETCH and DRAIN; acks seen without one are ignored.
  assign req = ((state_q == S_FETCH) || (state_q == S_DRAIN)) && !rst;
  assign ack = req && bus.imem_ack;

  // Next-state and datapath decisions for the fetch/present/drain cycle.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pc_next_d = pc_next_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    case (state_q)
      S_FETCH: begin
        if (bus.redirect) begin
          if (ack) begin
            // Response arrived with the redirect: drop it and refetch at once.
            pc_d = target;
          end else begin
            // The request cannot be withdrawn; park the target until it returns.
            pc_next_d = target;
            state_d   = S_DRAIN;
          end
        end else if (ack) begin
          inst_d    = bus.imem_rdata;
          inst_pc_d = pc_q;
          pc_d      = pc_q + 32'd4;
          state_d   = S_VALID;
        end
      end
      S_VALID: begin
        if (bus.redirect) begin
          pc_d    = target;
          state_d = S_FETCH;
        end else if (bus.inst_ready) begin
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (ack) begin
          // Stale data is discarded; a redirect in this same cycle is the newest.
          pc_d    = bus.redirect ? target : pc_next_q;
          state_d = S_FETCH;
        end else if (bus.redirect) begin
          pc_next_d = target;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      pc_next_q <= RESET_PC;
      inst_q    <= 32'd0;
      inst_pc_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_next_q <= pc_next_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_valid = (state_q == S_VALID) && !rst;

endmodule

// File: tb/tb_ifu.sv
// tb/tb_ifu.sv - scoreboard bench for ifu with random stimulus and a memory model
module tb_ifu;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

  logic clk;
  logic rst;
  ifu_if bus ();

  ifu #(.RESET_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_present = 0;
  int cyc_total = 0;

  // Scoreboard: pcs the decoder is expected to see next, in order.
  logic [31:0] exp_q[$];

  // Architectural model: next pc the decoder should be shown.
  logic [31:0] model_pc;

  // Memory model state.
  int   lat;
  int   age;
  bit   prev_req;
  bit   last_hs;
  bit   drv_prev_valid;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: drive inputs after the edge, update the model, answer memory.
  task automatic step(input bit r, input bit rd, input logic [31:0] rpc, input bit rdy, input bit noise);
    bit fresh;
    bit req_now;
    @(posedge clk);
    #1;
    rst             = r;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
    bus.inst_ready  = rdy;
    #1;
    fresh = bus.inst_valid && !drv_prev_valid;
    if (r) begin
      model_pc = RST_PC;
      exp_q.delete();
      exp_q.push_back(model_pc);
    end else if (rd) begin
      model_pc = {rpc[31:2], 2'b00};
      if (fresh && exp_q.size() > 0) begin
        // The instruction shown this cycle was legitimately presented.
        while (exp_q.size() > 1) void'(exp_q.pop_back());
      end else begin
        exp_q.delete();
      end
      exp_q.push_back(model_pc);
    end else if (bus.inst_valid && rdy) begin
      model_pc = model_pc + 32'd4;
      exp_q.push_back(model_pc);
    end
    drv_prev_valid = bus.inst_valid;

    req_now = bus.imem_req;
    if (r || !prev_req || last_hs) age = 0;
    else age++;
    if (req_now && !r && age >= lat) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = bus.imem_addr ^ KEY;
    end else if (!req_now && !r && noise) begin
      bus.imem_ack   = 1'($urandom_range(0, 1));
      bus.imem_rdata = $urandom;
    end else begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
    end
    last_hs  = req_now && bus.imem_ack;
    prev_req = req_now && !r;
  endtask

  // Monitor state from the previous negedge.
  bit          m_prev_valid = 0;
  bit          m_prev_rst   = 1;
  bit          m_prev_redir = 0;
  bit          m_prev_req   = 0;
  bit          m_prev_ack   = 0;
  logic [31:0] m_prev_addr  = 32'd0;
  logic [31:0] m_prev_inst  = 32'd0;
  logic [31:0] m_prev_ipc   = 32'd0;

  // Monitor: compares presentations against the scoreboard and checks protocol rules.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      chk(!bus.imem_req, "rst_req", 32'(bus.imem_req), 32'd0);
      chk(!bus.inst_valid, "rst_valid", 32'(bus.inst_valid), 32'd0);
      if (m_prev_rst) begin
        chk(bus.inst == 32'd0, "rst_inst", bus.inst, 32'd0);
        chk(bus.inst_pc == 32'd0, "rst_inst_pc", bus.inst_pc, 32'd0);
      end
    end else begin
      if (bus.inst_valid) chk(!bus.imem_req, "valid_no_req", 32'(bus.imem_req), 32'd0);
      if (bus.inst_valid && !m_prev_valid) begin
        n_present++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_inst", bus.inst_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk(bus.inst_pc == e, "inst_pc", bus.inst_pc, e);
          chk(bus.inst == (e ^ KEY), "inst", bus.inst, e ^ KEY);
        end
      end
      if (bus.inst_valid && m_prev_valid) begin
        chk(bus.inst == m_prev_inst, "hold_inst", bus.inst, m_prev_inst);
        chk(bus.inst_pc == m_prev_ipc, "hold_inst_pc", bus.inst_pc, m_prev_ipc);
      end
      if (m_prev_valid && m_prev_redir && !m_prev_rst)
        chk(!bus.inst_valid, "redirect_drop", 32'(bus.inst_valid), 32'd0);
      if (m_prev_req && !m_prev_ack && !m_prev_rst) begin
        chk(bus.imem_req, "req_hold", 32'(bus.imem_req), 32'd1);
        chk(bus.imem_addr == m_prev_addr, "addr_hold", bus.imem_addr, m_prev_addr);
      end
    end
    m_prev_valid = bus.inst_valid;
    m_prev_rst   = rst;
    m_prev_redir = bus.redirect;
    m_prev_req   = bus.imem_req;
    m_prev_ack   = bus.imem_ack;
    m_prev_addr  = bus.imem_addr;
    m_prev_inst  = bus.inst;
    m_prev_ipc   = bus.inst_pc;
  end

  // Watchdog so the run always ends.
  always @(posedge clk) begin
    cyc_total++;
    if (cyc_total > 20000) begin
      $display("FAIL watchdog: got %0d cycles expected under 20000", cyc_total);
      $fatal(1, "watchdog expired");
    end
  end

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 32'd0, 1, 0);
  endtask

  task automatic wait_valid(input string name);
    bit found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 32'd0, 0, 0);
      found = bus.inst_valid;
    end
    chk(found, name, 32'(found), 32'd1);
  endtask

  initial begin
    int vcnt;
    bit found;
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'd0;
    bus.inst_ready = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = 32'd0;
    model_pc = RST_PC;
    lat = 0; age = 0; prev_req = 0; last_hs = 0; drv_prev_valid = 0;

    // Streaming with same-cycle memory: one instruction every other cycle.
    do_reset(3);
    vcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 32'd0, 1, 0);
      if (i == 0) begin
        chk(bus.imem_req, "first_req", 32'(bus.imem_req), 32'd1);
        chk(bus.imem_addr == RST_PC, "first_addr", bus.imem_addr, RST_PC);
      end
      if (bus.inst_valid) vcnt++;
    end
    chk(vcnt == 10, "stream_rate", 32'(vcnt), 32'd10);

    // Decoder stall: instruction held, no fetch issued.
    lat = 1;
    wait_valid("stall_wait");
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 32'd0, 0, 0);
      chk(bus.inst_valid, "stall_valid", 32'(bus.inst_valid), 32'd1);
      chk(!bus.imem_req, "stall_req", 32'(bus.imem_req), 32'd0);
    end

    // Redirect while presenting, unaligned target.
    step(0, 1, 32'h0000_0103, 0, 0);
    step(0, 0, 32'd0, 0, 0);
    chk(bus.imem_req, "redir_valid_req", 32'(bus.imem_req), 32'd1);
    chk(bus.imem_addr == 32'h100, "redir_valid_addr", bus.imem_addr, 32'h100);
    for (int i = 0; i < 6; i++) step(0, 0, 32'd0, 1, 0);

    // Redirect while fetch of 0x8 is outstanding, slow memory.
    for (int pass = 0; pass < 2; pass++) begin
      lat = 3;
      do_reset(2);
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
        step(0, 0, 32'd0, 1, 0);
        found = bus.imem_req && (bus.imem_addr == 32'h8);
      end
      chk(found, "drain_wait", 32'(found), 32'd1);
      step(0, 1, 32'h40, 1, 0);
      if (pass == 0) step(0, 0, 32'd0, 1, 0);
      else step(0, 1, 32'h80, 1, 0);
      chk(bus.imem_addr == 32'h8, "drain_old_addr", bus.imem_addr, 32'h8);
      step(0, 0, 32'd0, 1, 0);
      step(0, 0, 32'd0, 1, 0);
      chk(bus.imem_req, "drain_next_req", 32'(bus.imem_req), 32'd1);
      chk(bus.imem_addr == (pass == 0 ? 32'h40 : 32'h80), "drain_next_addr",
          bus.imem_addr, (pass == 0 ? 32'h40 : 32'h80));
      for (int i = 0; i < 10; i++) step(0, 0, 32'd0, 1, 0);
    end

    // Address wrap at the top of memory.
    lat = 1;
    wait_valid("wrap_wait");
    step(0, 1, 32'hFFFF_FFFC, 1, 0);
    step(0, 0, 32'd0, 1, 0);
    chk(bus.imem_addr == 32'hFFFF_FFFC, "wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      step(0, 0, 32'd0, 1, 0);
      found = bus.imem_req && (bus.imem_addr != 32'hFFFF_FFFC);
    end
    chk(found && bus.imem_addr == 32'h0, "wrap_addr1", bus.imem_addr, 32'h0);

    // Reset while draining.
    lat = 3;
    wait_valid("rst_drain_wait");
    step(0, 0, 32'd0, 1, 0);
    step(0, 0, 32'd0, 1, 0);
    step(0, 1, 32'h200, 1, 0);
    step(1, 0, 32'd0, 1, 0);
    step(0, 0, 32'd0, 1, 0);
    chk(bus.imem_req, "rst_drain_req", 32'(bus.imem_req), 32'd1);
    chk(bus.imem_addr == RST_PC, "rst_drain_addr", bus.imem_addr, RST_PC);
    chk(!bus.inst_valid, "rst_drain_valid", 32'(bus.inst_valid), 32'd0);

    // Random traffic: latency, stalls, redirects, resets, stray acks.
    for (int i = 0; i < 400; i++) begin
      lat = $urandom_range(0, 3);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0,
           ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : $urandom,
           $urandom_range(0, 3) != 0, 1);
    end
    for (int i = 0; i < 8; i++) step(0, 0, 32'd0, 1, 0);
    chk(n_present >= 50, "liveness", 32'(n_present), 32'd50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
